// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM state type and width/reset defaults.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W   = 14;
  localparam int unsigned CPU_ADDR_W   = 12;
  localparam int unsigned CPU_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with registered storage and a flush input.
// Read data is the head entry; it stays stable until popped.
module fetch_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;

  // Occupancy next-state; pop is qualified by non-empty.
  always_comb begin
    count_d = count_q;
    if (push_i)
      count_d = count_d + 1'b1;
    if (pop_i && !empty_o)
      count_d = count_d - 1'b1;
  end

  // Storage, pointers and occupancy; flush drops all entries.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-based ROM prefetch into a tagged FIFO.
// Optional feature macro: FETCH_UNIT_STALL_CNT_EN adds the stall_cnt output.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned ADDR_W   = CPU_ADDR_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned RESET_PC = CPU_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_UNIT_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]     infl_q, infl_d;
  logic [ROM_LAT-1:0] pipe_v_q;
  logic [ADDR_W-1:0] pipe_a_q [ROM_LAT];

  logic              redirect_act, issue, credit_ok, push, pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_rd;

  // Redirect is ignored in IDLE and overrides everything else.
  assign redirect_act = redirect && (state_q != IDLE);
  assign credit_ok    = ({1'b0, fifo_count} + {1'b0, infl_q}) < (CW+1)'(DEPTH);
  assign issue        = (state_q == FETCH) && !halt && !redirect_act && credit_ok;
  assign push         = pipe_v_q[ROM_LAT-1] && !redirect_act;
  assign pop          = instr_valid && instr_ready && !redirect_act;

  // FSM next state, PC advance and ROM request generation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_rd_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    flush_cnt_d = flush_cnt_q;
    infl_d      = infl_q + CW'(issue) - CW'(push);
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (halt) state_d = HALT;
      HALT:  if (!halt) state_d = FETCH;
      FLUSH: begin
        if (flush_cnt_q == '0)
          state_d = halt ? HALT : FETCH;
        else
          flush_cnt_d = flush_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      rom_rd_d   = 1'b1;
      rom_addr_d = pc_q;
      pc_d       = pc_q + 1'b1;
    end
    if (redirect_act) begin
      state_d     = FLUSH;
      pc_d        = redirect_pc;
      flush_cnt_d = 2'(ROM_LAT - 1);
      infl_d      = '0;
    end
  end

  // State, PC, ROM request and in-flight bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= ADDR_W'(RESET_PC);
      flush_cnt_q <= '0;
      infl_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      flush_cnt_q <= flush_cnt_d;
      infl_q      <= infl_d;
    end
  end

  // Return tracker aligned to the ROM latency; clearing the valid bits on
  // redirect/reset discards every older word without a separate drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v_q <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++)
        pipe_a_q[i] <= '0;
    end else begin
      pipe_v_q[0] <= rom_rd_q && !redirect_act;
      pipe_a_q[0] <= rom_addr_q;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1] && !redirect_act;
        pipe_a_q[i] <= pipe_a_q[i-1];
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_i     (reset),
    .flush_i     (redirect_act),
    .push_i      (push),
    .push_data_i ({pipe_a_q[ROM_LAT-1], rom_data}),
    .pop_i       (pop),
    .rd_data_o   (fifo_rd),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rom_rd      = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_rd[ADDR_W+DATA_W-1:DATA_W];
  assign instr_data  = fifo_rd[DATA_W-1:0];

`ifdef FETCH_UNIT_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of FETCH cycles where only missing credit blocks issue.
  always_ff @(posedge clk) begin
    if (reset || redirect_act)
      stall_q <= '0;
    else if ((state_q == FETCH) && !halt && !credit_ok && (stall_q != '1))
      stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one ROM_LAT=1 instance for most scenarios and
// one ROM_LAT=2 instance for the redirect-with-reads-in-flight scenario.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rd1, redir1, halt1, v1, rdy1;
  logic [11:0] addr1, rpc1, ipc1;
  logic [13:0] data1, idata1;
  logic        rst2, rd2, redir2, halt2, v2, rdy2;
  logic [11:0] addr2, rpc2, ipc2, s2;
  logic [13:0] data2, idata2;
`ifdef FETCH_UNIT_STALL_CNT_EN
  logic [15:0] stall1, stall2;
`endif

  int passed = 0;
  int total  = 0;
  int pulses, ndeliv;

  fetch_unit #(.DATA_W(14), .ADDR_W(12), .DEPTH(4), .ROM_LAT(1), .RESET_PC(0)) dut1 (
    .clk(clk), .reset(rst1), .rom_rd(rd1), .rom_addr(addr1), .rom_data(data1),
    .redirect(redir1), .redirect_pc(rpc1), .halt(halt1), .instr_valid(v1),
    .instr_data(idata1), .instr_pc(ipc1), .instr_ready(rdy1)
`ifdef FETCH_UNIT_STALL_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  fetch_unit #(.DATA_W(14), .ADDR_W(12), .DEPTH(4), .ROM_LAT(2), .RESET_PC(0)) dut2 (
    .clk(clk), .reset(rst2), .rom_rd(rd2), .rom_addr(addr2), .rom_data(data2),
    .redirect(redir2), .redirect_pc(rpc2), .halt(halt2), .instr_valid(v2),
    .instr_data(idata2), .instr_pc(ipc2), .instr_ready(rdy2)
`ifdef FETCH_UNIT_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

  // ROM models: word = address, latency 1 and 2.
  always @(posedge clk) data1 <= {2'b00, addr1};
  always @(posedge clk) begin
    s2    <= addr2;
    data2 <= {2'b00, s2};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input int sel, input int lim, input string tag);
    int n = 0;
    while (((sel == 1) ? v1 : v2) !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 32'((sel == 1) ? v1 : v2), 32'd1);
  endtask

  initial begin
    rst1 = 1; redir1 = 0; rpc1 = '0; halt1 = 0; rdy1 = 1;
    rst2 = 1; redir2 = 0; rpc2 = '0; halt2 = 0; rdy2 = 1;
    tick(); tick();

    // Reset state
    chk("rst_rd",    32'(rd1),    32'd0);
    chk("rst_addr",  32'(addr1),  32'd0);
    chk("rst_valid", 32'(v1),     32'd0);
    chk("rst_data",  32'(idata1), 32'd0);
    chk("rst_pc",    32'(ipc1),   32'd0);
`ifdef FETCH_UNIT_STALL_CNT_EN
    chk("rst_stall", 32'(stall1), 32'd0);
`endif

    // Streaming start: rom_rd at cycle 2, instr_valid at ROM_LAT+1 after that
    rst1 = 0;
    tick(); chk("c1_rd", 32'(rd1), 32'd0);
    tick(); chk("c2_rd", 32'(rd1), 32'd1); chk("c2_addr", 32'(addr1), 32'd0);
    tick(); chk("c3_valid", 32'(v1), 32'd0); chk("c3_addr", 32'(addr1), 32'd1);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("stream_valid", 32'(v1), 32'd1);
      chk("stream_pc",    32'(ipc1), 32'(k));
      chk("stream_data",  32'(idata1), 32'(k));
      tick();
    end

    // Back-pressure: ready low for 20 cycles -> 4 fetches, head held at pc 0
    rst1 = 1; rdy1 = 0; tick(); rst1 = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rd1) pulses++;
    end
    chk("bp_pulses", 32'(pulses), 32'd4);
    chk("bp_valid",  32'(v1),     32'd1);
    chk("bp_headpc", 32'(ipc1),   32'd0);
`ifdef FETCH_UNIT_STALL_CNT_EN
    chk("bp_stall", 32'(stall1), 32'd15);
`endif
    rdy1 = 1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_rel_valid", 32'(v1), 32'd1);
      chk("bp_rel_pc",    32'(ipc1), 32'(k));
      tick();
    end

    // PC wrap at 2^ADDR_W-1
    rpc1 = 12'hFFE; redir1 = 1; tick(); redir1 = 0;
    chk("wrap_redir_valid", 32'(v1), 32'd0);
    wait_valid(1, 20, "wrap_timeout");
    chk("wrap_pc0", 32'(ipc1), 32'hFFE); tick();
    chk("wrap_pc1", 32'(ipc1), 32'hFFF); tick();
    chk("wrap_pc2", 32'(ipc1), 32'h000);
    chk("wrap_data2", 32'(idata1), 32'h000);

    // Halt with one read in flight
    rst1 = 1; tick(); rst1 = 0;
    tick(); tick();
    chk("halt_inflight", 32'(rd1), 32'd1);
    halt1 = 1; ndeliv = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("halt_nord", 32'(rd1), 32'd0);
      if (v1) begin
        ndeliv++;
        chk("halt_pc", 32'(ipc1), 32'd0);
      end
    end
    chk("halt_ndeliv", 32'(ndeliv), 32'd1);
    halt1 = 0;
    tick(); chk("resume_rd0", 32'(rd1), 32'd0);
    tick(); chk("resume_rd1", 32'(rd1), 32'd1); chk("resume_addr", 32'(addr1), 32'd1);

    // Redirect together with halt: redirect wins, HALT after FLUSH
    rpc1 = 12'h200; redir1 = 1; halt1 = 1; tick(); redir1 = 0;
    chk("rh_valid", 32'(v1), 32'd0);
    tick(); tick();
    chk("rh_state", 32'(dut1.state_q), 32'(HALT));
    chk("rh_nord",  32'(rd1), 32'd0);
    halt1 = 0;
    wait_valid(1, 20, "rh_timeout");
    chk("rh_pc", 32'(ipc1), 32'h200);

    // Reset with 3 entries buffered
    rst1 = 1; rdy1 = 0; tick(); rst1 = 0;
    repeat (6) tick();
    chk("r3_valid", 32'(v1), 32'd1);
    chk("r3_pc",    32'(ipc1), 32'd0);
    rst1 = 1; tick();
    chk("r3_rst_valid", 32'(v1),   32'd0);
    chk("r3_rst_rd",    32'(rd1),  32'd0);
    chk("r3_rst_pc",    32'(ipc1), 32'd0);
`ifdef FETCH_UNIT_STALL_CNT_EN
    chk("r3_rst_stall", 32'(stall1), 32'd0);
`endif
    rst1 = 0; rdy1 = 1;
    wait_valid(1, 20, "r3_timeout");
    chk("r3_first_pc", 32'(ipc1), 32'd0); tick();
    chk("r3_second_pc", 32'(ipc1), 32'd1);

    // ROM_LAT=2: redirect while two reads in flight
    rst2 = 0;
    tick(); tick(); tick();
    chk("l2_rd",   32'(rd2),   32'd1);
    chk("l2_addr", 32'(addr2), 32'd1);
    rpc2 = 12'h100; redir2 = 1; tick(); redir2 = 0;
    chk("l2_redir_valid", 32'(v2), 32'd0);
    wait_valid(2, 20, "l2_timeout");
    chk("l2_pc0",   32'(ipc2),   32'h100);
    chk("l2_data0", 32'(idata2), 32'h100); tick();
    chk("l2_pc1",   32'(ipc2),   32'h101);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL take parameter DATA_W, default 14, instruction word width.
REQ-002 The block SHALL take parameter ADDR_W, default 12, program address width.
REQ-003 The block SHALL take parameter DEPTH, default 4, prefetch buffer entries, a power of two, 2..16.
REQ-004 The block SHALL take parameter ROM_LAT, default 1, ROM read latency in cycles, 1..3.
REQ-005 The block SHALL take parameter RESET_PC, default 0, first fetch address after reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port rom_rd, output, 1 bit: ROM read strobe.
REQ-009 The block SHALL have port rom_addr, output, ADDR_W bits: ROM read address.
REQ-010 The block SHALL have port rom_data, input, DATA_W bits: ROM read data.
REQ-011 The block SHALL have port redirect, input, 1 bit: branch/jump request.
REQ-012 The block SHALL have port redirect_pc, input, ADDR_W bits: redirect target address.
REQ-013 The block SHALL have port halt, input, 1 bit: suspend issue of new fetches.
REQ-014 The block SHALL have port instr_valid, output, 1 bit: buffer head is valid.
REQ-015 The block SHALL have port instr_data, output, DATA_W bits: head instruction word.
REQ-016 The block SHALL have port instr_pc, output, ADDR_W bits: address of the head instruction.
REQ-017 The block SHALL have port instr_ready, input, 1 bit: the consumer accepts the head instruction.

Function
REQ-018 The block SHALL drive rom_rd and rom_addr from registers; the ROM returns data on rom_data ROM_LAT cycles after the cycle in which rom_rd=1 is presented.
REQ-019 The block SHALL implement an FSM with states IDLE, FETCH, HALT and FLUSH; reset enters IDLE, and IDLE goes to FETCH after one cycle.
REQ-020 In FETCH, the block SHALL issue rom_rd=1 when occupancy + in-flight < DEPTH; a pop in the same cycle earns no credit.
REQ-021 Each issue SHALL advance the PC by 1, wrapping from 2^ADDR_W-1 to 0.
REQ-022 Each returned word SHALL be pushed into the FIFO tagged with its fetch address; the FIFO SHALL never overflow.
REQ-023 A pop SHALL occur when instr_valid=1 and instr_ready=1; instr_data and instr_pc SHALL be held stable while instr_valid=1 and instr_ready=0.
REQ-024 A push into an empty FIFO SHALL raise instr_valid on the next cycle, giving a minimum rom_rd-to-instr_valid latency of ROM_LAT+1 cycles.
REQ-025 When halt=1 in FETCH, the block SHALL go to HALT: no new issue; in-flight words still land; pops continue; FETCH resumes the cycle after halt=0.
REQ-026 When redirect=1 in any non-IDLE state, the block SHALL:
- empty the FIFO;
- load the PC with redirect_pc;
- enter FLUSH for ROM_LAT cycles, discarding every returning word.
REQ-027 At the end of FLUSH, the block SHALL go to HALT if halt=1, otherwise to FETCH.
REQ-028 redirect SHALL take priority over halt, push and pop in the same cycle.
REQ-029 A redirect during FLUSH SHALL reload the PC and restart the FLUSH count.
REQ-030 instr_valid SHALL be 0 in the cycle after a redirect.

Reset
REQ-031 reset SHALL, at the next edge, set rom_rd=0, rom_addr=RESET_PC, instr_valid=0, FIFO empty, in-flight count 0, PC=RESET_PC, FSM=IDLE; instr_data and instr_pc SHALL reset to 0.
REQ-032 Reset asserted mid-operation SHALL abandon all in-flight reads; data returning after reset SHALL be discarded.

Configuration
REQ-033 With FETCH_UNIT_STALL_CNT_EN defined, the block SHALL add output stall_cnt, 16 bits, saturating, counting cycles in FETCH where issue is blocked by credit, cleared by reset or redirect.
REQ-034 Without FETCH_UNIT_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the FSM state typedef (fetch_state_t), the DATA_W/ADDR_W defaults (14/12) and RESET_PC.
REQ-036 The block SHALL contain one sub-module, fetch_fifo: a parametrised synchronous FIFO (DATA_W+ADDR_W wide, DEPTH entries, with flush input).

Verification
REQ-037 Bench: reset, ROM word = address, instr_ready=1, ROM_LAT=1 -> rom_rd first at cycle 2 after reset release; instr_pc 0,1,2,... consecutive cycles; instr_data = instr_pc.
REQ-038 Bench: instr_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 rom_rd pulses; head held at pc 0; release -> 4 pops, then streaming resumes at pc 4.
REQ-039 Bench: redirect=1, redirect_pc=0x100 while 2 reads in flight (ROM_LAT=2) -> no word from the old stream appears; next instr_pc=0x100, then 0x101.
REQ-040 Bench: PC=0xFFE, ADDR_W=12 -> instr_pc sequence 0xFFE, 0xFFF, 0x000.
REQ-041 Bench: halt=1 for 10 cycles with 1 read in flight -> that word delivered, no rom_rd during halt, fetch restarts 1 cycle after halt=0; redirect+halt together -> redirect wins, state HALT after FLUSH.
REQ-042 Bench: reset pulsed while FIFO holds 3 entries -> instr_valid=0 next cycle, first delivered instr_pc=RESET_PC; with FETCH_UNIT_STALL_CNT_EN defined, stall_cnt=0.
